// File: rtl/video_src_switch.sv
// Frame-synchronous selector between the colour-bar generator and the camera stream, with a camera vsync watchdog.
// Build option VIDEO_SRC_AUTO_RETURN_EN: no failover lock, so the camera is re-armed automatically once it is good again.
module video_src_switch #(
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd3_000_000,
  parameter logic [3:0]  MIN_GOOD_FRAMES = 4'd2,
  parameter logic        VS_POL          = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_cam,
  input  logic        bar_hs,
  input  logic        bar_vs,
  input  logic        bar_de,
  input  logic [23:0] bar_rgb,
  input  logic        cam_hs,
  input  logic        cam_vs,
  input  logic        cam_de,
  input  logic [23:0] cam_rgb,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [23:0] rgb,
  output logic        src_cam,
  output logic        cam_lost,
  output logic        switching
);

  typedef enum logic [1:0] {
    ST_BAR     = 2'd0,
    ST_ARM_CAM = 2'd1,
    ST_CAM     = 2'd2,
    ST_ARM_BAR = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_bar_vs_d;
  logic        r_cam_vs_d;
  logic        w_bar_edge;
  logic        w_cam_edge;
  logic [23:0] r_wd_cnt;
  logic [3:0]  r_good_cnt;
  logic        r_cam_lost;
  logic        w_cam_good;
  logic        w_fail_lock;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_src_cam;
  logic        r_switching;
  logic        w_hs;
  logic        w_vs;
  logic        w_de;
  logic [23:0] w_rgb;

  // Delay registers reset to the asserted level so reset release never looks like an edge.
  assign w_bar_edge = (bar_vs == VS_POL) && (r_bar_vs_d != VS_POL);
  assign w_cam_edge = (cam_vs == VS_POL) && (r_cam_vs_d != VS_POL);

  // Vsync history for edge detection on both sources
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bar_vs_d <= VS_POL;
      r_cam_vs_d <= VS_POL;
    end else begin
      r_bar_vs_d <= bar_vs;
      r_cam_vs_d <= cam_vs;
    end
  end

  // Camera watchdog: timeout counter, good-frame counter and lost flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt   <= 24'd0;
      r_good_cnt <= 4'd0;
      r_cam_lost <= 1'b1;
    end else begin
      if (w_cam_edge) begin
        r_wd_cnt <= 24'd0;
      end else if (r_wd_cnt != TIMEOUT_CYCLES) begin
        r_wd_cnt <= r_wd_cnt + 24'd1;
      end

      // An edge wins over a saturated timeout so the first frame after a loss still counts.
      if (w_cam_edge) begin
        if (r_good_cnt != MIN_GOOD_FRAMES) begin
          r_good_cnt <= r_good_cnt + 4'd1;
        end
      end else if (r_wd_cnt == TIMEOUT_CYCLES) begin
        r_good_cnt <= 4'd0;
      end

      if (r_wd_cnt == TIMEOUT_CYCLES) begin
        r_cam_lost <= 1'b1;
      end else if (r_good_cnt == MIN_GOOD_FRAMES) begin
        r_cam_lost <= 1'b0;
      end
    end
  end

  assign w_cam_good = !r_cam_lost && (r_good_cnt == MIN_GOOD_FRAMES);

`ifdef VIDEO_SRC_AUTO_RETURN_EN
  assign w_fail_lock = 1'b0;
`else
  logic r_fail_lock;
  logic w_lock_set;

  assign w_lock_set = ((r_state == ST_CAM) || (r_state == ST_ARM_CAM)) && r_cam_lost;

  // Failover lock: held until the operator deselects the camera
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_lock <= 1'b0;
    end else if (!sel_cam) begin
      r_fail_lock <= 1'b0;
    end else if (w_lock_set) begin
      r_fail_lock <= 1'b1;
    end
  end

  assign w_fail_lock = r_fail_lock;
`endif

  // Source-selection state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; source changes only at the incoming source's vsync edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BAR: begin
        if (sel_cam && w_cam_good && !w_fail_lock) begin
          w_state_nxt = ST_ARM_CAM;
        end else begin
          w_state_nxt = ST_BAR;
        end
      end
      ST_ARM_CAM: begin
        if (r_cam_lost || !sel_cam) begin
          w_state_nxt = ST_BAR;
        end else if (w_cam_edge) begin
          w_state_nxt = ST_CAM;
        end else begin
          w_state_nxt = ST_ARM_CAM;
        end
      end
      ST_CAM: begin
        if (!sel_cam || r_cam_lost) begin
          w_state_nxt = ST_ARM_BAR;
        end else begin
          w_state_nxt = ST_CAM;
        end
      end
      ST_ARM_BAR: begin
        if (w_bar_edge) begin
          w_state_nxt = ST_BAR;
        end else begin
          w_state_nxt = ST_ARM_BAR;
        end
      end
      default: begin
        w_state_nxt = ST_BAR;
      end
    endcase
  end

  // Mux on the next state so the edge cycle that enters a source already carries that source
  always_comb begin
    w_hs  = bar_hs;
    w_vs  = bar_vs;
    w_de  = bar_de;
    w_rgb = bar_rgb;
    case (w_state_nxt)
      ST_BAR: begin
        w_hs  = bar_hs;
        w_vs  = bar_vs;
        w_de  = bar_de;
        w_rgb = bar_rgb;
      end
      ST_CAM: begin
        w_hs  = cam_hs;
        w_vs  = cam_vs;
        w_de  = cam_de;
        w_rgb = cam_rgb;
      end
      ST_ARM_CAM: begin
        w_hs  = cam_hs;
        w_vs  = cam_vs;
        w_de  = 1'b0;
        w_rgb = 24'd0;
      end
      ST_ARM_BAR: begin
        w_hs  = bar_hs;
        w_vs  = bar_vs;
        w_de  = 1'b0;
        w_rgb = 24'd0;
      end
      default: begin
        w_hs  = 1'b0;
        w_vs  = 1'b0;
        w_de  = 1'b0;
        w_rgb = 24'd0;
      end
    endcase
  end

  // Output registers; status flags track the same state as the data they accompany
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs        <= 1'b0;
      r_vs        <= 1'b0;
      r_de        <= 1'b0;
      r_rgb       <= 24'd0;
      r_src_cam   <= 1'b0;
      r_switching <= 1'b0;
    end else begin
      r_hs        <= w_hs;
      r_vs        <= w_vs;
      r_de        <= w_de;
      r_rgb       <= w_rgb;
      r_src_cam   <= (w_state_nxt == ST_CAM);
      r_switching <= (w_state_nxt == ST_ARM_CAM) || (w_state_nxt == ST_ARM_BAR);
    end
  end

  assign hs        = r_hs;
  assign vs        = r_vs;
  assign de        = r_de;
  assign rgb       = r_rgb;
  assign src_cam   = r_src_cam;
  assign switching = r_switching;
  assign cam_lost  = r_cam_lost;

endmodule

// File: doc/video_src_switch.md
Name: video_src_switch

Overview:
Frame-synchronous source arbiter between the internal colour-bar generator and the retimed camera stream; both streams are on the same pixel clock. It selects one stream for the display path and changes source only at the incoming source's vertical-sync boundary. A vsync watchdog detects a lost camera and forces failover to the colour bar. It sits between the pattern generator / camera frame-read path and the display encoder.

Parameters:
TIMEOUT_CYCLES, 24'd3_000_000, clk cycles without a camera vs assertion edge before the camera is declared lost.
MIN_GOOD_FRAMES, 4'd2, consecutive camera vs assertion edges needed before the camera counts as good.
VS_POL, 1'b1, assertion level of bar_vs and cam_vs; 1 means positive.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
sel_cam  in  1  level; 1 requests the camera, 0 requests the colour bar
bar_hs  in  1  colour-bar hsync
bar_vs  in  1  colour-bar vsync
bar_de  in  1  colour-bar data enable
bar_rgb  in  24  colour-bar pixel {r,g,b}
cam_hs  in  1  camera hsync
cam_vs  in  1  camera vsync
cam_de  in  1  camera data enable
cam_rgb  in  24  camera pixel {r,g,b}
hs  out  1  selected hsync
vs  out  1  selected vsync
de  out  1  selected data enable
rgb  out  24  selected pixel
src_cam  out  1  1 when the output carries the camera stream (state CAM)
cam_lost  out  1  camera watchdog flag
switching  out  1  1 while in ARM_CAM or ARM_BAR

Behaviour:
- Single clk domain. rst is synchronous and active-high, with priority over all other logic.
- Vsync edge detect per source: x_vs_d is a register, reset to VS_POL. An edge is (x_vs==VS_POL) && (x_vs_d!=VS_POL), so no spurious edge occurs on reset release.
- Watchdog:
  - wd_cnt (24 bit) clears on a cam edge and otherwise increments, saturating at TIMEOUT_CYCLES.
  - When wd_cnt reaches TIMEOUT_CYCLES: cam_lost=1 and good_cnt=0.
  - Each cam edge increments good_cnt, saturating at MIN_GOOD_FRAMES.
  - cam_lost clears in the cycle after good_cnt reaches MIN_GOOD_FRAMES.
  - cam_good = !cam_lost && good_cnt==MIN_GOOD_FRAMES.
  - Reset values: cam_lost=1, good_cnt=0, wd_cnt=0.
- fail_lock: set when CAM or ARM_CAM leaves because of cam_lost; cleared whenever sel_cam==0.
- FSM, reset state BAR:
  - BAR → ARM_CAM when sel_cam && cam_good && !fail_lock.
  - ARM_CAM → CAM on a cam edge.
  - ARM_CAM → BAR immediately if cam_lost or !sel_cam (abort).
  - CAM → ARM_BAR when !sel_cam || cam_lost. If both occur in the same cycle, go to ARM_BAR; fail_lock is set only if cam_lost.
  - ARM_BAR → BAR on a bar edge.
  - ARM_BAR is never aborted: a sel_cam re-assert waits until BAR is reached.
- Output mux, registered, 1-cycle latency from inputs:
  - BAR: bar_* stream.
  - CAM: cam_* stream.
  - ARM_CAM: hs/vs from cam, de=0, rgb=0.
  - ARM_BAR: hs/vs from bar, de=0, rgb=0.
  - A transition edge that moves the FSM into CAM or BAR selects the new stream in that same input cycle, so the first vs assertion of the new source appears on the output.
- Reset outputs: hs=~VS_POL-independent 0, vs=0, de=0, rgb=0, src_cam=0, switching=0, cam_lost=1.
- src_cam and switching are decoded from the registered state and align with the registered data.

Optional Feature:
Macro VIDEO_SRC_AUTO_RETURN_EN.
- Defined: fail_lock is tied to 0. After a failover the block returns to the camera automatically once cam_good is true and sel_cam is still 1.
- Undefined: fail_lock behaves as described above. After a failover, sel_cam must go to 0 and back to 1 before the camera is re-armed.

Test Plan:
- Bench settings: TIMEOUT_CYCLES=1000, MIN_GOOD_FRAMES=2, 200-cycle frames with vs high for 5 cycles.
- Reset with sel_cam=1 and no cam vs -> stays in BAR, cam_lost=1, output equals bar stream delayed 1 cycle, de follows bar_de.
- Camera starts; after 2 cam edges cam_lost falls; FSM enters ARM_CAM (switching=1, de=0, rgb=0). At the 3rd cam edge src_cam=1 and vs rises 1 cycle after cam_vs.
- In CAM, drop sel_cam mid-frame -> ARM_BAR with de=0 until the next bar_vs rising edge, then BAR; out vs rises 1 cycle after bar_vs.
- In CAM, stop cam_vs -> 1000 cycles after the last edge cam_lost=1 and ARM_BAR is entered. With the macro undefined: camera recovery alone keeps BAR; a sel_cam 1→0→1 pulse re-arms. With the macro defined: the return to CAM happens automatically after 2 good frames.
- sel_cam=0 during ARM_CAM -> next cycle BAR, no cam edge is needed.
- Assert rst while in CAM mid-frame -> next cycle all outputs are at their reset values, state is BAR, cam_lost=1.
